// File: rtl/ce_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ce_gen_pkg
//  Description : Shared constants, channel-index width helper and the
//                write-rejection cause encoding for ce_frac_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
package ce_gen_pkg;

    localparam int CE_MAX_CH = 16;

    typedef enum logic [1:0] {
        CE_ERR_NONE  = 2'd0,
        CE_ERR_DEN0  = 2'd1,
        CE_ERR_RANGE = 2'd2,
        CE_ERR_CH    = 2'd3
    } ce_err_e;

    // Channel select is at least one bit wide even for a single channel.
    function automatic int ce_ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ce_frac_chan.sv
`default_nettype none
// ============================================================================
//  Module      : ce_frac_chan
//  Description : One fractional clock-enable channel: accumulator, active and
//                pending ratio registers, and boundary-aligned apply logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module ce_frac_chan
    import ce_gen_pkg::*;
#(
    parameter int               ACC_W   = 16,
    parameter logic [ACC_W-1:0] RST_NUM = 1,
    parameter logic [ACC_W-1:0] RST_DEN = 20
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             pause,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_num,
    input  logic [ACC_W-1:0] wr_den,
    output logic             ce,
    output logic             tog,
    output logic             pend
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic [ACC_W-1:0] pend_num_q, pend_num_d;
    logic [ACC_W-1:0] pend_den_q, pend_den_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;
    logic             tog_q, tog_d;

    logic [ACC_W:0]   sum;
    logic             enabled;
    logic             apply;

    always_comb begin
        acc_d      = acc_q;
        num_d      = num_q;
        den_d      = den_q;
        pend_num_d = pend_num_q;
        pend_den_d = pend_den_q;
        pend_d     = pend_q;
        ce_d       = 1'b0;
        tog_d      = tog_q;
        apply      = 1'b0;

        sum     = {1'b0, acc_q} + {1'b0, num_q};
        enabled = (num_q != '0);

        if (sync) begin
            acc_d = '0;
            tog_d = 1'b0;
            apply = pend_q;
        end else if (!pause) begin
            if (!enabled) begin
                apply = pend_q;
            end else if (sum >= {1'b0, den_q}) begin
                // sum - den < den always fits back into ACC_W bits.
                acc_d = sum[ACC_W-1:0] - den_q;
                ce_d  = 1'b1;
                tog_d = ~tog_q;
                apply = pend_q;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        if (apply) begin
            num_d  = pend_num_q;
            den_d  = pend_den_q;
            acc_d  = '0;
            pend_d = 1'b0;
        end

        // A write landing on an apply edge re-arms pending after the old one is consumed.
        if (wr_en) begin
            pend_num_d = wr_num;
            pend_den_d = wr_den;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            num_q      <= RST_NUM;
            den_q      <= RST_DEN;
            pend_num_q <= '0;
            pend_den_q <= '0;
            pend_q     <= 1'b0;
            ce_q       <= 1'b0;
            tog_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            num_q      <= num_d;
            den_q      <= den_d;
            pend_num_q <= pend_num_d;
            pend_den_q <= pend_den_d;
            pend_q     <= pend_d;
            ce_q       <= ce_d;
            tog_q      <= tog_d;
        end
    end

    a_acc_lt_den: assert property (@(posedge clk_sys) disable iff (!reset_n) acc_q < den_q);

    assign ce   = ce_q;
    assign tog  = tog_q;
    assign pend = pend_q;

endmodule
`default_nettype wire

// File: rtl/ce_frac_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ce_frac_gen
//  Description : Multi-channel fractional clock-enable generator. Validates
//                configuration writes and fans sync/pause out to the channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module ce_frac_gen
    import ce_gen_pkg::*;
#(
    parameter int                      NUM_CH  = 4,
    parameter int                      ACC_W   = 16,
    parameter logic [NUM_CH*ACC_W-1:0] RST_NUM = {NUM_CH{16'd1}},
    parameter logic [NUM_CH*ACC_W-1:0] RST_DEN = {NUM_CH{16'd20}},
    localparam int                     CH_W    = ce_ch_w(NUM_CH)
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              pause,
    input  logic              sync,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] tog
);

    localparam logic [CH_W:0] C_NUM_CH = (CH_W + 1)'(NUM_CH);

    ce_err_e err_cause;
    logic    wr_ok;
    logic    cfg_err_q, cfg_err_d;

    always_comb begin
        err_cause = CE_ERR_NONE;
        if ({1'b0, cfg_ch} >= C_NUM_CH) begin
            err_cause = CE_ERR_CH;
        end else if (cfg_den == '0) begin
            err_cause = CE_ERR_DEN0;
        end else if (cfg_num > cfg_den) begin
            err_cause = CE_ERR_RANGE;
        end
        wr_ok     = cfg_wr && (err_cause == CE_ERR_NONE);
        cfg_err_d = cfg_wr && (err_cause != CE_ERR_NONE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_ok && (cfg_ch == CH_W'(i));

        ce_frac_chan #(
            .ACC_W   (ACC_W),
            .RST_NUM (RST_NUM[i*ACC_W +: ACC_W]),
            .RST_DEN (RST_DEN[i*ACC_W +: ACC_W])
        ) u_chan (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .pause   (pause),
            .sync    (sync),
            .wr_en   (sel),
            .wr_num  (cfg_num),
            .wr_den  (cfg_den),
            .ce      (ce[i]),
            .tog     (tog[i]),
            .pend    (cfg_pend[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_ce_frac_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ce_frac_gen
//  Description : Directed scoreboard bench for ce_frac_gen (3 channels).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ce_frac_gen;

    localparam int NCH = 3;
    localparam int AW  = 16;

    logic            clk_sys = 1'b0;
    logic            reset_n = 1'b0;
    logic            pause   = 1'b0;
    logic            sync    = 1'b0;
    logic            cfg_wr  = 1'b0;
    logic [1:0]      cfg_ch  = '0;
    logic [AW-1:0]   cfg_num = '0;
    logic [AW-1:0]   cfg_den = '0;
    logic            cfg_err;
    logic [NCH-1:0]  cfg_pend;
    logic [NCH-1:0]  ce;
    logic [NCH-1:0]  tog;

    ce_frac_gen #(
        .NUM_CH  (NCH),
        .ACC_W   (AW),
        .RST_NUM ({16'd0, 16'd0, 16'd1}),
        .RST_DEN ({16'd7, 16'd7, 16'd20})
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .pause    (pause),
        .sync     (sync),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_num  (cfg_num),
        .cfg_den  (cfg_den),
        .cfg_err  (cfg_err),
        .cfg_pend (cfg_pend),
        .ce       (ce),
        .tog      (tog)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit tog;
    } exp_t;

    exp_t           q_ce[NCH][$];
    logic [NCH-1:0] exp_tog = '0;
    int             total = 0;
    int             bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic expect_ce(input int ch, input int c);
        exp_tog[ch] = ~exp_tog[ch];
        q_ce[ch].push_back('{cyc: c, tog: exp_tog[ch]});
    endtask

    task automatic check_drained(input string name);
        for (int ch = 0; ch < NCH; ch++) check(name, q_ce[ch].size(), 0);
    endtask

    task automatic write(input int ch, input int num, input int den);
        cfg_wr  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_num = AW'(num);
        cfg_den = AW'(den);
        tick(1);
        cfg_wr  = 1'b0;
    endtask

    // Monitor: every observed ce pops the channel's next expected pulse.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (ce[ch]) begin
                    total++;
                    if (q_ce[ch].size() == 0) begin
                        bad++;
                        $display("FAIL ce_unexpected ch%0d: pulse at cycle %0d, none expected", ch, cyc);
                    end else begin
                        exp_t e;
                        e = q_ce[ch].pop_front();
                        if (e.cyc != cyc || e.tog != tog[ch]) begin
                            bad++;
                            $display("FAIL ce_pulse ch%0d: got cycle %0d tog %0d expected cycle %0d tog %0d",
                                     ch, cyc, tog[ch], e.cyc, e.tog);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int c0, s, p, q, r, t, cnt;
        int offs[3];
        offs[0] = 3; offs[1] = 5; offs[2] = 7;

        // Reset state
        tick(3);
        check("rst_ce", int'(ce), 0);
        check("rst_tog", int'(tog), 0);
        check("rst_pend", int'(cfg_pend), 0);
        check("rst_err", int'(cfg_err), 0);
        reset_n = 1'b1;
        c0 = cyc;

        // 1/20 on channel 0: pulses every 20 edges, tog period 40
        for (int k = 1; k <= 10; k++) expect_ce(0, c0 + 20 * k);
        wait_to(c0 + 205);
        check_drained("a_drain");

        // 3/7 on disabled channel 1: applies on the edge after the write
        write(1, 3, 7);
        check("b_pend_rise", int'(cfg_pend), 3'b010);
        tick(1);
        check("b_pend_fall", int'(cfg_pend), 3'b000);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        s = cyc;
        exp_tog = '0;
        check("b_sync_tog", int'(tog), 0);
        for (int k = 1; k <= 3; k++) expect_ce(0, s + 20 * k);
        for (int m = 0; m < 10; m++)
            for (int j = 0; j < 3; j++) expect_ce(1, s + 7 * m + offs[j]);
        wait_to(s + 72);
        check_drained("b_drain");

        // Disable channel 1: pending lands on its second-next pulse
        expect_ce(1, s + 73);
        expect_ce(1, s + 75);
        write(1, 0, 7);
        check("b_dis_pend", int'(cfg_pend[1]), 1);
        wait_to(s + 76);
        check("b_dis_fall", int'(cfg_pend), 0);

        // Retime channel 0 to 1/4 five cycles after its pulse
        p = s + 80;
        expect_ce(0, p);
        wait_to(p + 4);
        expect_ce(0, p + 20);
        for (int k = 1; k <= 3; k++) expect_ce(0, p + 20 + 4 * k);
        write(0, 1, 4);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (cfg_pend[0]) cnt++;
            if (k < 15) tick(1);
        end
        check("c_pend_len", cnt, 15);
        check("c_pend_fall", int'(cfg_pend[0]), 0);
        wait_to(p + 34);
        check_drained("c_drain");

        // Back to 1/20, then pause for 50 cycles
        q = p + 36;
        expect_ce(0, q);
        write(0, 1, 20);
        wait_to(q + 5);
        pause = 1'b1;
        wait_to(q + 10);
        write(2, 0, 5);
        check("d_pause_wr", int'(cfg_pend), 3'b100);
        wait_to(q + 55);
        check("d_tog_hold", int'(tog[0]), int'(exp_tog[0]));
        check("d_pend_hold", int'(cfg_pend[2]), 1);
        pause = 1'b0;
        expect_ce(0, q + 70);
        tick(1);
        check("d_pend_apply", int'(cfg_pend), 0);
        wait_to(q + 72);
        check_drained("d_drain");

        // Rejected writes
        write(0, 1, 0);
        check("e_den0_err", int'(cfg_err), 1);
        check("e_den0_pend", int'(cfg_pend), 0);
        tick(1);
        check("e_den0_clr", int'(cfg_err), 0);
        write(0, 5, 4);
        check("e_range_err", int'(cfg_err), 1);
        check("e_range_pend", int'(cfg_pend), 0);
        tick(1);
        check("e_range_clr", int'(cfg_err), 0);
        write(3, 1, 4);
        check("e_ch_err", int'(cfg_err), 1);
        check("e_ch_pend", int'(cfg_pend), 0);
        tick(1);
        check("e_ch_clr", int'(cfg_err), 0);
        expect_ce(0, q + 90);
        wait_to(q + 92);
        check_drained("e_drain");

        // sync+pause together, then reset while a write is pending
        r = cyc;
        sync  = 1'b1;
        pause = 1'b1;
        tick(1);
        sync = 1'b0;
        exp_tog = '0;
        check("f_sync_tog", int'(tog), 0);
        write(0, 1, 4);
        check("f_pend", int'(cfg_pend), 3'b001);
        reset_n = 1'b0;
        #1;
        check("f_rst_pend", int'(cfg_pend), 0);
        check("f_rst_tog", int'(tog), 0);
        pause = 1'b0;
        tick(2);
        reset_n = 1'b1;
        t = cyc;
        check("f_elapsed", t - r, 4);
        expect_ce(0, t + 20);
        expect_ce(0, t + 40);
        wait_to(t + 42);
        check_drained("f_drain");
        check("f_end_pend", int'(cfg_pend), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
